axil_cmd_master: RTL and testbench

- AXI4-Lite master that turns single-beat register commands into AXI transactions. It is the initiator counterpart of the PIR alarm AXI slave.
- Used by PL-side control logic, such as the OV7670 capture sequencer, to read PIR status and write alarm control registers without the PS.
- Exactly one transaction is outstanding at a time.
- A simple valid/ready command port and a response port sit in front of the AXI master channels.

---
 rtl/axil_cmd_master_if.sv | 56 +++++
 rtl/axil_cmd_master.sv | 253 +++++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite channel bundle between axil_cmd_master and its slave.
// The master modport drives addresses, data, valids and response readies.
interface axil_cmd_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one AXI
// transaction out, one response back. Every output comes straight from a flop.
module axil_cmd_master #(
    parameter int          C_M00_AXI_DATA_WIDTH = 32,
    parameter int          C_M00_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_TIMEOUT_CYCLES     = 1024
) (
    input  logic                                m00_axi_aclk,
    input  logic                                m00_axi_areset,

    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic                                rsp_write,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic                                timeout_flag,

    axil_cmd_master_if.master                   m00_axi
);

    localparam int          DW            = C_M00_AXI_DATA_WIDTH;
    localparam int          AW            = C_M00_AXI_ADDR_WIDTH;
    localparam int          SW            = C_M00_AXI_DATA_WIDTH / 8;
    localparam logic [31:0] TIMEOUT_LIMIT = C_TIMEOUT_CYCLES;
    localparam bit          TIMEOUT_EN    = (C_TIMEOUT_CYCLES != 32'd0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } state_e;

    state_e          state_q,     state_d;
    logic [AW-1:0]   addr_q,      addr_d;
    logic [DW-1:0]   wdata_q,     wdata_d;
    logic [SW-1:0]   wstrb_q,     wstrb_d;
    logic            write_q,     write_d;
    logic            aw_done_q,   aw_done_d;
    logic            w_done_q,    w_done_d;
    logic            awvalid_q,   awvalid_d;
    logic            wvalid_q,    wvalid_d;
    logic            bready_q,    bready_d;
    logic            arvalid_q,   arvalid_d;
    logic            rready_q,    rready_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q,  rsp_resp_d;
    logic [15:0]     tcnt_q,      tcnt_d;
    logic            tflag_q,     tflag_d;

    logic            in_wait_s;
    logic [15:0]     tcnt_inc_s;
    logic            tcnt_hit_s;

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        // The wait counter saturates so a hung slave can never wrap it back to zero.
        in_wait_s  = (state_q == ST_WRITE) || (state_q == ST_WRESP) ||
                     (state_q == ST_READ)  || (state_q == ST_RDATA);
        tcnt_inc_s = (tcnt_q == 16'hFFFF) ? tcnt_q : (tcnt_q + 16'd1);
        tcnt_hit_s = TIMEOUT_EN && ({16'd0, tcnt_inc_s} == TIMEOUT_LIMIT);
        tcnt_d     = in_wait_s ? tcnt_inc_s : tcnt_q;
        tflag_d    = tflag_q | (in_wait_s & tcnt_hit_s);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    write_d     = cmd_write;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    tcnt_d      = 16'd0;
                    tflag_d     = 1'b0;
                    if (cmd_write) begin
                        state_d   = ST_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_READ;
                        arvalid_d = 1'b1;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_WRITE: begin
                // AW and W retire independently; either order or both at once is fine.
                if (awvalid_q && m00_axi.awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (wvalid_q && m00_axi.wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = ST_WRESP;
                    bready_d = 1'b1;
                end else begin
                    state_d  = ST_WRITE;
                end
            end
            ST_WRESP: begin
                if (m00_axi.bvalid) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m00_axi.bresp;
                    rsp_rdata_d = {DW{1'b0}};
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    bready_d    = 1'b1;
                end
            end
            ST_READ: begin
                if (m00_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            ST_RDATA: begin
                if (m00_axi.rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m00_axi.rdata;
                    rsp_resp_d  = m00_axi.rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    rready_d    = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q     <= ST_IDLE;
            addr_q      <= {AW{1'b0}};
            wdata_q     <= {DW{1'b0}};
            wstrb_q     <= {SW{1'b0}};
            write_q     <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DW{1'b0}};
            rsp_resp_q  <= 2'b00;
            tcnt_q      <= 16'd0;
            tflag_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            tcnt_q      <= tcnt_d;
            tflag_q     <= tflag_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_write       = write_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_resp        = rsp_resp_q;
    assign timeout_flag    = tflag_q;

    assign m00_axi.awaddr  = addr_q;
    assign m00_axi.awprot  = 3'b000;
    assign m00_axi.awvalid = awvalid_q;
    assign m00_axi.wdata   = wdata_q;
    assign m00_axi.wstrb   = wstrb_q;
    assign m00_axi.wvalid  = wvalid_q;
    assign m00_axi.bready  = bready_q;
    assign m00_axi.araddr  = addr_q;
    assign m00_axi.arprot  = 3'b000;
    assign m00_axi.arvalid = arvalid_q;
    assign m00_axi.rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomized bench for axil_cmd_master: a delay-programmable AXI-Lite slave plus
// a cycle-count reference model predicting latency, beat counts, data and timeout.
module tb_axil_cmd_master;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int T_LIM = 8;

    logic           clk = 1'b0;
    logic           areset;
    logic           cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]  cmd_addr;
    logic [DW-1:0]  cmd_wdata;
    logic [3:0]     cmd_wstrb;
    logic           rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0]  rsp_rdata;
    logic [1:0]     rsp_resp;
    logic           timeout_flag;

    axil_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axil_cmd_master #(
        .C_M00_AXI_DATA_WIDTH(DW),
        .C_M00_AXI_ADDR_WIDTH(AW),
        .C_TIMEOUT_CYCLES(T_LIM)
    ) dut (
        .m00_axi_aclk   (clk),
        .m00_axi_areset (areset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_wstrb      (cmd_wstrb),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_write      (rsp_write),
        .rsp_rdata      (rsp_rdata),
        .rsp_resp       (rsp_resp),
        .timeout_flag   (timeout_flag),
        .m00_axi        (axi)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic slave_quiet();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'($urandom);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = $urandom;
        axi.rresp   = 2'($urandom);
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    // One command; slave readies are levels from cycle a_dly/w_dly/r_dly after
    // accept, B/R valid arrive b_dly/rd_dly cycles after the address phase ends.
    task automatic run_txn(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int a_dly, input int w_dly,
                           input int b_dly, input int r_dly, input int rd_dly,
                           input logic [1:0] resp, input logic [31:0] rdat, input int hold);
        int waits, rsp_at, rel;
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        int aw_hs, w_hs, ar_hs;
        bit b_done, r_done, got_rsp, exp_flag;
        logic [31:0] exp_rdata;

        waits     = wr ? imax(a_dly, w_dly) + 1 + b_dly : r_dly + 1 + rd_dly;
        rsp_at    = waits + 1;
        exp_flag  = (waits >= T_LIM);
        exp_rdata = wr ? 32'h0 : rdat;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0;
        b_done = 1'b0; r_done = 1'b0; got_rsp = 1'b0;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        check_val("cmd_ready_idle", cmd_ready, 1);
        tick();
        rel = 1;
        cmd_valid = 1'(($urandom & 32'h1));
        cmd_write = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);

        while (!got_rsp && rel <= rsp_at + 50) begin
            check_val("tflag_run", timeout_flag, (rel - 1 >= T_LIM));
            if (rsp_valid) begin
                got_rsp = 1'b1;
                check_val("rsp_latency", rel, rsp_at);
            end else begin
                check_val("cmd_ready_busy", cmd_ready, 0);
                if (axi.awvalid) begin
                    aw_cnt++;
                    check_val("awaddr", axi.awaddr, addr);
                end
                if (axi.wvalid) begin
                    w_cnt++;
                    check_val("wdata", axi.wdata, data);
                    check_val("wstrb", axi.wstrb, strb);
                end
                if (axi.arvalid) begin
                    ar_cnt++;
                    check_val("araddr", axi.araddr, addr);
                end
                if (axi.bready) b_cnt++;
                if (axi.rready) r_cnt++;

                axi.awready = wr && (rel >= a_dly);
                axi.wready  = wr && (rel >= w_dly);
                axi.bvalid  = !b_done && (aw_hs > 0) && (w_hs > 0) &&
                              (rel >= imax(aw_hs, w_hs) + 1 + b_dly);
                axi.bresp   = axi.bvalid ? resp : 2'($urandom);
                axi.arready = !wr && (rel >= r_dly);
                axi.rvalid  = !r_done && (ar_hs > 0) && (rel >= ar_hs + 1 + rd_dly);
                axi.rdata   = axi.rvalid ? rdat : $urandom;
                axi.rresp   = axi.rvalid ? resp : 2'($urandom);

                if (axi.awvalid && axi.awready) aw_hs = rel;
                if (axi.wvalid && axi.wready)   w_hs  = rel;
                if (axi.arvalid && axi.arready) ar_hs = rel;
                if (axi.bvalid && axi.bready)   b_done = 1'b1;
                if (axi.rvalid && axi.rready)   r_done = 1'b1;
                tick();
                rel++;
            end
        end
        slave_quiet();

        if (wr) begin
            check_val("aw_cycles", aw_cnt, a_dly);
            check_val("w_cycles", w_cnt, w_dly);
            check_val("bready_cycles", b_cnt, b_dly + 1);
            check_val("ar_on_write", ar_cnt, 0);
        end else begin
            check_val("ar_cycles", ar_cnt, r_dly);
            check_val("rready_cycles", r_cnt, rd_dly + 1);
            check_val("aw_on_read", aw_cnt + w_cnt, 0);
        end

        check_val("rsp_seen", got_rsp, 1);
        if (got_rsp) begin
            check_val("rsp_write", rsp_write, wr);
            check_val("rsp_rdata", rsp_rdata, exp_rdata);
            check_val("rsp_resp", rsp_resp, resp);
            check_val("tflag_rsp", timeout_flag, exp_flag);
            check_val("cmd_ready_rsp", cmd_ready, 0);
            for (int h = 0; h < hold; h++) begin
                cmd_valid = 1'b1;
                tick();
                check_val("rsp_hold_valid", rsp_valid, 1);
                check_val("rsp_hold_rdata", rsp_rdata, exp_rdata);
                check_val("rsp_hold_resp", rsp_resp, resp);
                check_val("cmd_ready_hold", cmd_ready, 0);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check_val("rsp_valid_done", rsp_valid, 0);
            check_val("cmd_ready_back", cmd_ready, 1);
            check_val("tflag_sticky", timeout_flag, exp_flag);
        end else begin
            cmd_valid = 1'b0;
            pulse_reset();
        end
    endtask

    // Reset while AW is stalled and the timeout flag is already set.
    task automatic reset_mid();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'h8;
        cmd_wdata = 32'hA5A5_0001;
        cmd_wstrb = 4'hF;
        check_val("rst_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        slave_quiet();
        for (int r = 1; r < 10; r++) tick();
        check_val("pre_rst_awvalid", axi.awvalid, 1);
        check_val("pre_rst_tflag", timeout_flag, 1);
        pulse_reset();
        check_val("rst_awvalid", axi.awvalid, 0);
        check_val("rst_wvalid", axi.wvalid, 0);
        check_val("rst_arvalid", axi.arvalid, 0);
        check_val("rst_bready", axi.bready, 0);
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_tflag", timeout_flag, 0);
        check_val("rst_rdata", rsp_rdata, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wr;
        int a, w, b, r, rd;
        areset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        slave_quiet();
        repeat (3) tick();
        areset = 1'b0;

        check_val("init_cmd_ready", cmd_ready, 1);
        check_val("init_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        check_val("init_rsp_valid", rsp_valid, 0);
        check_val("init_rsp_rdata", rsp_rdata, 0);
        check_val("init_rsp_resp", rsp_resp, 0);
        check_val("init_tflag", timeout_flag, 0);
        check_val("init_addr", axi.awaddr, 0);
        check_val("init_wdata", axi.wdata, 0);
        check_val("init_prot", {axi.awprot, axi.arprot}, 0);

        // wr addr data strb aw w b ar rd resp rdata hold
        run_txn(1'b1, 4'h4, 32'h0000_0003, 4'hF, 1, 1, 0, 0, 0, 2'd0, 32'h0, 0);
        run_txn(1'b1, 4'hC, 32'h1234_5678, 4'h3, 4, 1, 0, 0, 0, 2'd0, 32'h0, 0);
        run_txn(1'b1, 4'h0, 32'hCAFE_0000, 4'hC, 1, 3, 1, 0, 0, 2'd3, 32'h0, 0);
        run_txn(1'b0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 1, 5, 2'd2, 32'h0000_0001, 0);
        run_txn(1'b0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 2, 0, 2'd0, 32'hDEAD_BEEF, 4);
        run_txn(1'b1, 4'h4, 32'h0000_0010, 4'hF, 1, 1, 5, 0, 0, 2'd0, 32'h0, 0);
        run_txn(1'b1, 4'h4, 32'h0000_0011, 4'hF, 1, 1, 6, 0, 0, 2'd1, 32'h0, 1);
        run_txn(1'b0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 1, 6, 2'd0, 32'h5555_AAAA, 0);
        run_txn(1'b1, 4'h4, 32'h0000_0020, 4'hF, 1, 1, 20, 0, 0, 2'd0, 32'h0, 2);
        reset_mid();
        run_txn(1'b0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'd0, 32'h0000_0042, 0);

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom);
            a  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : $urandom_range(1, 3);
            w  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : $urandom_range(1, 3);
            b  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2);
            r  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : $urandom_range(1, 3);
            rd = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 2);
            run_txn(wr, 4'($urandom), $urandom, 4'($urandom), a, w, b, r, rd,
                    2'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
